// File: rtl/gemm_seq_pkg.sv
// Shared types for the GEMM sequencer: matrix register numbers and FSM states.
package datapath_types;

    // Width of one matrix register index inside a command.
    localparam int MAT_REGW = 4;

    // Register numbers carried by one GEMM command.
    typedef struct packed {
        logic [MAT_REGW-1:0] rd;
        logic [MAT_REGW-1:0] rs1;
        logic [MAT_REGW-1:0] rs2;
        logic [MAT_REGW-1:0] rs3;
    } matrix_num_t;

    // Sequencer phases: idle, weight load, input stream, result drain.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADW  = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } gemm_state_t;

endpackage

// File: rtl/gemm_seq_cmd_buf.sv
// Single-entry pending command buffer. Lets the functional unit hand off the
// next GEMM while the current one runs; forces a weight load until weights
// have been loaded at least once since reset.
module gemm_cmd_buf
    import datapath_types::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  matrix_num_t cmd_num,
    input  logic        cmd_new_weight,
    input  logic        pop_i,
    input  logic        w_loaded_i,
    output logic        pend_valid_o,
    output matrix_num_t pend_num_o,
    output logic        pend_new_weight_o
);

    logic        pend_valid_q, pend_valid_d;
    matrix_num_t pend_num_q, pend_num_d;
    logic        pend_nw_q, pend_nw_d;

    assign cmd_ready         = ~pend_valid_q;
    assign pend_valid_o      = pend_valid_q;
    assign pend_num_o        = pend_num_q;
    // Array weights are undefined until the first load completes.
    assign pend_new_weight_o = pend_nw_q | ~w_loaded_i;

    // Accept on handshake, release on dispatch (never both in one cycle).
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_num_d   = pend_num_q;
        pend_nw_d    = pend_nw_q;
        if (pop_i) begin
            pend_valid_d = 1'b0;
        end
        if (cmd_valid && cmd_ready) begin
            pend_valid_d = 1'b1;
            pend_num_d   = cmd_num;
            pend_nw_d    = cmd_new_weight;
        end
    end

    // Buffer registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pend_valid_q <= 1'b0;
            pend_num_q   <= '0;
            pend_nw_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_num_q   <= pend_num_d;
            pend_nw_q    <= pend_nw_d;
        end
    end

endmodule

// File: rtl/gemm_seq.sv
// GEMM sequencer: turns a command into weight-row reads, input/psum row
// reads, array strobes and result write-back, one command in flight.
module gemm_seq
    import datapath_types::*;
#(
    parameter int DIM  = 4,
    parameter int REGW = MAT_REGW
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  matrix_num_t          cmd_num,
    input  logic                 cmd_new_weight,
    output logic                 rda_ren,
    output logic [REGW-1:0]      rda_reg,
    output logic [$clog2(DIM)-1:0] rda_row,
    output logic                 rdb_ren,
    output logic [REGW-1:0]      rdb_reg,
    output logic [$clog2(DIM)-1:0] rdb_row,
    output logic                 arr_wload,
    output logic                 arr_in_valid,
    input  logic                 arr_out_valid,
    output logic                 wb_en,
    output logic [REGW-1:0]      wb_reg,
    output logic [$clog2(DIM)-1:0] wb_row,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int RW = $clog2(DIM);
    localparam int WW = $clog2(DIM + 1);
    localparam logic [RW-1:0] R_LAST = RW'(DIM - 1);
    localparam logic [WW-1:0] W_LAST = WW'(DIM - 1);
    localparam logic [WW-1:0] W_FULL = WW'(DIM);

    gemm_state_t   state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [WW-1:0] w_q, w_d;
    matrix_num_t   act_q, act_d;
    logic          w_loaded_q, w_loaded_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          wload_q, in_valid_q;
    logic          ld_rd, st_rd;

    logic          pend_valid;
    matrix_num_t   pend_num;
    logic          pend_nw;
    logic          dispatch;

    assign dispatch = (state_q == IDLE) && pend_valid;

    gemm_cmd_buf u_cmd_buf (
        .CLK               (CLK),
        .nRST              (nRST),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_num           (cmd_num),
        .cmd_new_weight    (cmd_new_weight),
        .pop_i             (dispatch),
        .w_loaded_i        (w_loaded_q),
        .pend_valid_o      (pend_valid),
        .pend_num_o        (pend_num),
        .pend_new_weight_o (pend_nw)
    );

    assign busy         = (state_q != IDLE) || pend_valid;
    assign done         = done_q;
    assign err          = err_q;
    assign arr_wload    = wload_q;
    assign arr_in_valid = in_valid_q;

    // Next-state, read requests and write-back decode.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        w_d        = w_q;
        act_d      = act_q;
        w_loaded_d = w_loaded_q;
        done_d     = 1'b0;
        err_d      = err_q;
        ld_rd      = 1'b0;
        st_rd      = 1'b0;
        rda_ren    = 1'b0;
        rda_reg    = '0;
        rda_row    = '0;
        rdb_ren    = 1'b0;
        rdb_reg    = '0;
        rdb_row    = '0;
        wb_en      = 1'b0;
        wb_reg     = '0;
        wb_row     = '0;

        unique case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    act_d   = pend_num;
                    r_d     = '0;
                    w_d     = '0;
                    state_d = pend_nw ? LOADW : STREAM;
                end
            end
            LOADW: begin
                ld_rd   = 1'b1;
                rda_ren = 1'b1;
                rda_reg = act_q.rs2;
                rda_row = r_q;
                if (r_q == R_LAST) begin
                    r_d        = '0;
                    w_loaded_d = 1'b1;
                    state_d    = STREAM;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            STREAM: begin
                st_rd   = 1'b1;
                rda_ren = 1'b1;
                rda_reg = act_q.rs1;
                rda_row = r_q;
                rdb_ren = 1'b1;
                rdb_reg = act_q.rs3;
                rdb_row = r_q;
                if (r_q == R_LAST) begin
                    r_d     = '0;
                    state_d = DRAIN;
                end else begin
                    r_d = r_q + 1'b1;
                end
            end
            DRAIN: begin
                // All results already written during STREAM: leave at once.
                if (w_q == W_FULL) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Result rows are only meaningful once inputs are streaming.
        if (arr_out_valid) begin
            if ((state_q == STREAM || state_q == DRAIN) && (w_q < W_FULL)) begin
                wb_en  = 1'b1;
                wb_reg = act_q.rd;
                wb_row = w_q[RW-1:0];
                w_d    = w_q + 1'b1;
                if (w_q == W_LAST) begin
                    done_d = 1'b1;
                    if (state_q == DRAIN) begin
                        state_d = IDLE;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State, counters and the one-stage strobe pipeline.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            r_q        <= '0;
            w_q        <= '0;
            act_q      <= '0;
            w_loaded_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wload_q    <= 1'b0;
            in_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            w_q        <= w_d;
            act_q      <= act_d;
            w_loaded_q <= w_loaded_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wload_q    <= ld_rd;
            in_valid_q <= st_rd;
        end
    end

endmodule

// File: doc/gemm_seq.md
# gemm_seq

Systolic-array-side sequencer that receives GEMM commands (matrix register numbers rd/rs1/rs2/rs3 plus the new-weight flag) from the GEMM functional unit. It turns each command into row-by-row matrix-register-file read requests, array load/stream strobes and result write-back strobes. It holds one pending command so the functional unit can hand off the next GEMM while the current one runs. One command is in flight at a time.

## Interface
Parameters:
- DIM, 4: array dimension; rows per matrix.
- REGW, 4: matrix register index width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_num  in  matrix_num_t  {rd, rs1, rs2, rs3}, each REGW bits.
- cmd_new_weight  in  1  reload weights from rs2.
- rda_ren  out  1  read port A request (weights, then inputs).
- rda_reg  out  REGW  port A register.
- rda_row  out  $clog2(DIM)  port A row.
- rdb_ren  out  1  read port B request (partial sums).
- rdb_reg  out  REGW  port B register.
- rdb_row  out  $clog2(DIM)  port B row.
- arr_wload  out  1  array latches weight row (data from port A, 1-cycle read).
- arr_in_valid  out  1  array consumes input and psum row.
- arr_out_valid  in  1  array presents one result row.
- wb_en  out  1  write result row.
- wb_reg  out  REGW  write register (= active rd).
- wb_row  out  $clog2(DIM)  write row.
- busy  out  1  state != IDLE or pending command held.
- done  out  1  one-cycle pulse per completed GEMM.
- err  out  1  sticky; arr_out_valid received outside STREAM/DRAIN or beyond DIM rows.

## Operation
- Pending buffer: one entry. cmd_ready = !pend_valid. Handshake loads cmd_num and cmd_new_weight and sets pend_valid.
- Dispatch: in IDLE with pend_valid, the buffer moves to the active registers and pend_valid clears. A simultaneous new handshake is not possible, because cmd_ready was 0.
- w_loaded flag: cleared by reset, set on LOADW exit. If !w_loaded, new_weight is forced to 1.
- FSM gemm_state_t:
  - IDLE: dispatch to LOADW if new_weight, else to STREAM.
  - LOADW: row counter r runs 0..DIM-1. rda_ren=1, rda_reg=rs2, rda_row=r. Goes to STREAM after r=DIM-1.
  - STREAM: r runs 0..DIM-1. rda_ren=1, rda_reg=rs1, rdb_ren=1, rdb_reg=rs3, both rows=r. Goes to DRAIN after r=DIM-1.
  - DRAIN: waits for remaining results.
- Strobe timing: arr_wload and arr_in_valid are the LOADW/STREAM read enables delayed one register stage.
- Write-back counter w resets to 0 on dispatch.
  - In STREAM or DRAIN: wb_en = arr_out_valid, wb_reg = rd, wb_row = w, and w increments.
  - The w = DIM-1 write sets done next cycle and moves the FSM to IDLE the same edge.
  - This holds even if the write happens during STREAM: the FSM finishes issuing rows first and then exits DRAIN immediately.
- arr_out_valid is ignored (no wb_en, err set) when it arrives in IDLE/LOADW or after DIM writes.
- Reset values: every output 0 except cmd_ready=1. State IDLE, counters 0, pend_valid=0, w_loaded=0, err=0.
- Reset mid-operation aborts the command with no done. The pending command is discarded.

## Timing
- Handshake at edge t. Dispatch at edge t+1 if IDLE.
- With new_weight, DIM=4:
  - LOADW reads in cycles t+1..t+4; arr_wload in t+2..t+5.
  - STREAM reads in t+5..t+8; arr_in_valid in t+6..t+9.
- Without new_weight, STREAM starts at t+1.
- done comes 1 cycle after the final wb_en. The next dispatch can occur on the edge that ends the done cycle.
- cmd_ready returns to 1 in the cycle after dispatch.

## Structure
- Shared package (datapath_types): matrix_num_t struct {rd, rs1, rs2, rs3}; gemm_state_t enum {IDLE, LOADW, STREAM, DRAIN}.
- Sub-module gemm_cmd_buf: single-entry pending buffer containing pend_valid, the data registers, the forced-new-weight logic and ready generation.
- FSM, counters and strobe pipeline live in gemm_seq.

## Test plan
- Reset then cmd {rd=3, rs1=1, rs2=2, rs3=4}, new_weight=0 (first command) -> LOADW forced; rda_reg=2 rows 0..3 in t+1..t+4; arr_wload t+2..t+5; rs1/rs3 reads t+5..t+8.
- Second cmd, new_weight=0 -> no LOADW; STREAM reads begin t+1.
- Four arr_out_valid pulses in DRAIN, with gaps -> wb_en rows 0..3 to rd=3; done one cycle after the 4th; busy falls.
- Command offered while busy -> accepted once (cmd_ready then 0); third command stalls until dispatch; back-to-back dispatch right after done.
- arr_out_valid in IDLE and a 5th pulse -> no wb_en; err=1 and sticky.
- nRST asserted mid-STREAM -> all outputs to reset values immediately; no done; pending command lost.
